// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for the shared CPU external bus.
// Active-low requests in, registered one-cold active-low grant out.
// Ownership changes only when no transfer is outstanding, and every
// handover passes through at least one idle cycle with no grant asserted.
module bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned MAX_HOLD    = 16
) (
  input  logic                           cpu_clk,
  input  logic                           cpu_rstn,
  input  logic [NUM_MASTERS-1:0]         m_reqn,
  input  logic                           bus_asn,
  input  logic                           bus_rdyn,
  output logic [NUM_MASTERS-1:0]         m_grntn,
  output logic [$clog2(NUM_MASTERS)-1:0] owner,
  output logic                           granted
);

  localparam int unsigned OW = $clog2(NUM_MASTERS);
  localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [OW-1:0]          rr_ptr, rr_ptr_d;
  logic [HW-1:0]          hold_cnt, hold_cnt_d;
  logic [NUM_MASTERS-1:0] m_grntn_d;
  logic [OW-1:0]          owner_d;
  logic                   granted_d;

  logic                   any_req;
  logic [OW-1:0]          win;
  logic                   xfer_busy;
  logic [NUM_MASTERS-1:0] other_reqs;
  logic                   other_req;
  logic                   do_release;
  logic                   do_preempt;

  // First requester found searching upward from rr_ptr, wrapping
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!any_req && !m_reqn[OW'((32'(rr_ptr) + i) % NUM_MASTERS)]) begin
        any_req = 1'b1;
        win     = OW'((32'(rr_ptr) + i) % NUM_MASTERS);
      end
    end
  end

  // Release / preemption qualifiers for the current owner
  always_comb begin
    xfer_busy         = !bus_asn && bus_rdyn;
    other_reqs        = ~m_reqn;
    other_reqs[owner] = 1'b0;
    other_req         = |other_reqs;
    do_release        = m_reqn[owner] && !xfer_busy;
    do_preempt        = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) &&
                        other_req && !xfer_busy;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    m_grntn_d  = m_grntn;
    owner_d    = owner;
    granted_d  = granted;
    rr_ptr_d   = rr_ptr;
    hold_cnt_d = hold_cnt;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = GRANT;
          m_grntn_d  = ~(NUM_MASTERS'(1) << win);
          owner_d    = win;
          granted_d  = 1'b1;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (do_release || do_preempt) begin
          state_d    = IDLE;
          m_grntn_d  = '1;
          granted_d  = 1'b0;
          hold_cnt_d = '0;
          rr_ptr_d   = (owner == OW'(NUM_MASTERS - 1)) ? '0 : owner + OW'(1);
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt_d = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        m_grntn_d = '1;
        granted_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any grant immediately
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      state_q  <= IDLE;
      m_grntn  <= '1;
      owner    <= '0;
      granted  <= 1'b0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      state_q  <= state_d;
      m_grntn  <= m_grntn_d;
      owner    <= owner_d;
      granted  <= granted_d;
      rr_ptr   <= rr_ptr_d;
      hold_cnt <= hold_cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: two arbiters (MAX_HOLD=4 and MAX_HOLD=0) share stimulus.
// A behavioural model predicts each cycle's grant outputs into queues that
// a negedge monitor pops and compares.
module tb_bus_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic [N-1:0] reqn;
  logic         asn;
  logic         rdyn;

  logic [N-1:0] g_a, g_b;
  logic [1:0]   o_a, o_b;
  logic         v_a, v_b;

  bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(4)) dut_a (
    .cpu_clk(clk), .cpu_rstn(rstn), .m_reqn(reqn), .bus_asn(asn),
    .bus_rdyn(rdyn), .m_grntn(g_a), .owner(o_a), .granted(v_a)
  );

  bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(0)) dut_b (
    .cpu_clk(clk), .cpu_rstn(rstn), .m_reqn(reqn), .bus_asn(asn),
    .bus_rdyn(rdyn), .m_grntn(g_b), .owner(o_b), .granted(v_b)
  );

  typedef struct packed {
    logic [N-1:0] g;
    logic [1:0]   o;
    logic         v;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  // Model state per DUT: busy (owning), owner, search start, cycles held
  bit mb[2];
  int mo[2];
  int mp[2];
  int mh[2];
  int lim[2] = '{4, 0};
  logic [N-1:0] rq_r;

  function automatic exp_t model_exp(int k);
    exp_t e;
    e.v = mb[k];
    e.o = 2'(mo[k]);
    e.g = mb[k] ? ~(4'(1) << mo[k]) : 4'b1111;
    return e;
  endfunction

  function automatic void model_step(int k);
    bit xbusy;
    bit oth;
    if (!rstn) begin
      mb[k] = 0; mo[k] = 0; mp[k] = 0; mh[k] = 0;
    end else if (!mb[k]) begin
      for (int j = 0; j < N; j++) begin
        int m;
        m = (mp[k] + j) % N;
        if (reqn[m] == 1'b0) begin
          mb[k] = 1; mo[k] = m; mh[k] = 0;
          break;
        end
      end
    end else begin
      xbusy = (asn == 1'b0) && (rdyn == 1'b1);
      oth = 0;
      for (int j = 0; j < N; j++)
        if (j != mo[k] && reqn[j] == 1'b0) oth = 1;
      if ((reqn[mo[k]] && !xbusy) ||
          (lim[k] != 0 && mh[k] >= lim[k] && oth && !xbusy)) begin
        mb[k] = 0;
        mp[k] = (mo[k] + 1) % N;
      end else begin
        mh[k]++;
      end
    end
  endfunction

  function automatic void check(string name, exp_t act, exp_t exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got grntn=%b owner=%0d granted=%b, want grntn=%b owner=%0d granted=%b",
                  name, $time, act.g, act.o, act.v, exp.g, exp.o, exp.v);
  endfunction

  // Apply one cycle of inputs, predict, and queue the expected outputs
  task automatic step(input logic r, input logic [N-1:0] rq, input logic a, input logic rd);
    rstn = r; reqn = rq; asn = a; rdyn = rd;
    model_step(0);
    model_step(1);
    @(posedge clk);
    q_a.push_back(model_exp(0));
    q_b.push_back(model_exp(1));
    #1;
  endtask

  // Monitor: compare registered outputs away from the active edge
  always @(negedge clk) begin
    if (q_a.size() > 0) check("dut_a_maxhold4", {g_a, o_a, v_a}, q_a.pop_front());
    if (q_b.size() > 0) check("dut_b_maxhold0", {g_b, o_b, v_b}, q_b.pop_front());
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; reqn = '1; asn = 1'b1; rdyn = 1'b1; rq_r = '1;

    // Reset, idle, single request from master 1, then release
    repeat (2) step(0, 4'b1111, 1, 1);
    repeat (3) step(1, 4'b1111, 1, 1);
    repeat (2) step(1, 4'b1101, 1, 1);
    repeat (2) step(1, 4'b1111, 1, 1);

    // Fairness: everyone requests, owner drops request in its 2nd grant cycle
    for (int c = 0; c < 20; c++) begin
      logic [N-1:0] rq;
      rq = '0;
      if (mb[0] && mh[0] >= 1) rq[mo[0]] = 1'b1;
      step(1, rq, 1, 1);
    end

    // Transfer protection: master 2 drops request mid-transfer
    step(0, 4'b1111, 1, 1);
    repeat (2) step(1, 4'b1011, 1, 1);
    step(1, 4'b1011, 0, 1);
    repeat (5) step(1, 4'b1111, 0, 1);
    step(1, 4'b1111, 0, 0);
    repeat (3) step(1, 4'b1111, 1, 1);

    // Preemption (dut_a) vs. none (dut_b): masters 0 and 3 contend
    step(0, 4'b1111, 1, 1);
    step(1, 4'b1110, 1, 1);
    repeat (30) step(1, 4'b0110, 1, 1);
    repeat (4) step(1, 4'b0111, 1, 1);
    repeat (3) step(1, 4'b1111, 1, 1);

    // Long hold by master 0 with master 1 waiting
    step(0, 4'b1111, 1, 1);
    repeat (100) step(1, 4'b1100, 1, 1);
    repeat (4) step(1, 4'b1101, 1, 1);
    repeat (2) step(1, 4'b1111, 1, 1);

    // Reset while master 1 owns the bus mid-transfer, then all request
    repeat (3) step(1, 4'b1101, 1, 1);
    step(1, 4'b1101, 0, 1);
    step(0, 4'b1101, 0, 1);
    repeat (3) step(1, 4'b0000, 1, 1);

    // Randomized traffic
    repeat (2000) begin
      logic r;
      r = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 3) == 0) rq_r = 4'($urandom);
      step(r, rq_r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    #1;
    chk_cnt++;
    if (q_a.size() == 0 && q_b.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d/%0d entries left, want 0/0", q_a.size(), q_b.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the shared CPU external bus. It takes active-low bus requests from up to `NUM_MASTERS` bus masters (the IF- and MEM-stage bus interfaces, DMA and similar) and returns a registered active-low grant to exactly one of them. Ownership changes only at transfer boundaries. An optional hold limit stops any single master from monopolising the bus. It sits at SoC level between the masters' `bus_reqn`/`bus_grntn` pins and the bus fabric.

## Interface
- `NUM_MASTERS`, default 4: number of requesters. Legal range is 2..16.
- `MAX_HOLD`, default 16: grant cycles after which a contended owner is preempted. A value of 0 disables preemption.
- `cpu_clk` input, 1 bit: the only clock. All logic uses its rising edge.
- `cpu_rstn` input, 1 bit: reset, synchronous and active-low.
- `m_reqn` input, NUM_MASTERS bits: per-master request, active-low.
- `bus_asn` input, 1 bit: shared bus address strobe, active-low, driven by the current owner.
- `bus_rdyn` input, 1 bit: shared bus ready from the slave, active-low.
- `m_grntn` output, NUM_MASTERS bits: per-master grant, active-low, registered, one-cold or all-ones.
- `owner` output, $clog2(NUM_MASTERS) bits: index of the granted master. It holds the last owner while idle.
- `granted` output, 1 bit: high while any grant is asserted, registered.

## Operation
- The block has two states, IDLE and GRANT. All outputs are registered.
- `xfer_busy` = (`bus_asn`==0) && (`bus_rdyn`==1). This means a transfer is outstanding.
- Round-robin pointer `rr_ptr` sets the search order `rr_ptr`, `rr_ptr`+1, …, wrapping modulo NUM_MASTERS. The first master with `m_reqn` low wins.
- IDLE:
  - If no request is present, stay in IDLE with all grants high.
  - If a request is present, pick the winner W. Next state is GRANT with `m_grntn[W]`=0, `owner`=W, `granted`=1 and `hold_cnt`=0.
- GRANT:
  - `hold_cnt` increments every cycle and saturates at MAX_HOLD.
  - Release occurs when `m_reqn[owner]`=1 and `xfer_busy`=0.
  - Preempt occurs when MAX_HOLD≠0, `hold_cnt`==MAX_HOLD, some other master has `m_reqn` low, and `xfer_busy`=0.
  - On release or preempt, the next state is IDLE: all `m_grntn`=1, `granted`=0, `rr_ptr`=(`owner`+1) mod NUM_MASTERS.
  - Otherwise stay in GRANT. Other requests are ignored.
- The owner keeps its grant while `xfer_busy`=1, even if it drops its request or the hold limit has been reached.
- IDLE always lasts at least one cycle between owners. This dead cycle guarantees no two grants overlap, even for a single clock edge.
- A master whose request is dropped before it is granted receives nothing. Requests are not latched.
- `hold_cnt` width is $clog2(MAX_HOLD+1), with a minimum of 1 bit.

## Timing
- Reset: when `cpu_rstn`=0 at a rising edge, the following values hold after that edge:
  - `m_grntn` all ones
  - `granted`=0
  - `owner`=0
  - `rr_ptr`=0
  - `hold_cnt`=0
  - state IDLE
- Reset applied mid-grant or mid-transfer releases the grant at that edge without waiting for `xfer_busy`.
- Grant latency: a request sampled low at edge k while in IDLE produces its grant after edge k. This is 1 cycle.
- Release latency: a release condition true at edge k deasserts the grant after edge k. The next grant can appear after edge k+1 at the earliest.
- Handover is therefore 2 cycles from the owner's last grant cycle to the new owner's first grant cycle.
- Grant duration under preemption: `hold_cnt` is 0 in the first grant cycle, so preemption ends the grant after MAX_HOLD+1 cycles if `xfer_busy`=0 at that point. Otherwise it ends on the first later cycle with `xfer_busy`=0.
- Simultaneous requests in IDLE are resolved by `rr_ptr` order only.
- Owner release together with another request in the same cycle: the other request is granted 2 cycles later, as normal.

## Test plan
- Reset then single request, NUM_MASTERS=4:
  - Stimulus: hold `m_reqn`=4'b1111 for 3 cycles, then drive `m_reqn`=4'b1101.
  - Required: the cycle after the request, `m_grntn`=4'b1101, `owner`=1, `granted`=1.
  - Then drive `m_reqn`=4'b1111 with `bus_asn`=1. Required: grants return to 4'b1111 next cycle.
- Round-robin fairness: hold `m_reqn`=4'b0000 continuously, with each owner releasing after 2 cycles.
  - Required: owners appear in order 0,1,2,3,0.
  - Each owner is separated by exactly one all-ones `m_grntn` cycle.
- Transfer protection: owner 2 drops its request while `bus_asn`=0 and `bus_rdyn`=1 for 5 cycles.
  - Required: `m_grntn[2]` stays 0 through those 5 cycles.
  - Required: the grant deasserts the cycle after `bus_rdyn` goes 0.
- Preemption, MAX_HOLD=4: master 0 holds its request and master 3 requests from cycle 1.
  - Required: master 0 is granted for exactly 5 cycles, followed by 1 dead cycle, then `owner`=3.
- No preemption, MAX_HOLD=0: master 0 requests for 100 cycles while master 1 also requests.
  - Required: master 0 keeps the grant for all 100 cycles. Master 1 is granted 2 cycles after master 0 releases.
- Reset mid-transfer: master 1 is granted with `xfer_busy`=1 when `cpu_rstn`=0 is applied for one edge.
  - Required: after that edge, `m_grntn`=4'b1111, `owner`=0, `granted`=0.
  - Required: re-arbitration restarts from master 0.
